pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised pipeline-register chain for the pipelined MIPS core, replacing fixed-width hand-wired stage registers with one block of STAGES identical stages. Each stage carries an opaque payload plus destination-register metadata and a valid bit. Per-stage flush, global stall and built-in load-use hazard detection are included. It sits between the decode outputs (payload = control bits, operands, immediate, PC+4) and the execute/memory/write-back logic.

## Interface
- DATA_WIDTH, 64, payload bits per stage (≥1)
- STAGES, 3, number of register stages (≥2)
- REG_ADDR_WIDTH, 5, register-file address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  payload at input is a real instruction
- in_data  in  DATA_WIDTH  payload entering stage 0
- in_dst  in  REG_ADDR_WIDTH  destination register of entering instruction
- in_dst_wr  in  1  entering instruction writes in_dst
- in_load  in  1  entering instruction is a load
- in_src1, in_src2  in  REG_ADDR_WIDTH each  source registers of entering instruction
- stall_in  in  1  freeze entire chain
- flush_mask  in  STAGES  bit k: stage k becomes a bubble this edge
- in_ready  out  1  input accepted this cycle
- hazard  out  1  load-use stall active this cycle
- stage_valid  out  STAGES  valid bit of each stage
- out_valid  out  1  valid bit of stage STAGES-1
- out_data  out  DATA_WIDTH  payload of stage STAGES-1
- out_dst  out  REG_ADDR_WIDTH  destination of stage STAGES-1
- out_dst_wr  out  1  write-enable of stage STAGES-1, gated by out_valid
- stall_count  out  32  number of cycles with hazard=1

## Operation
- Stage k holds {valid, data, dst, dst_wr, load}. A bubble is valid=0 with all other fields 0.
- hazard (combinational) = in_valid & valid[0] & load[0] & dst_wr[0] & (dst[0]≠0) & (dst[0]==in_src1 | dst[0]==in_src2). Register 0 never causes a hazard.
- in_ready = ~stall_in & ~hazard.
- Priority per stage, per edge: reset > flush_mask[k] > stall_in (hold) > hazard > advance.
- stall_in=1: every unflushed stage holds its contents; input is not accepted.
- hazard=1, stall_in=0: stage 0 loads a bubble, stages 1..STAGES-1 advance; upstream must hold its inputs (in_ready=0).
- Advance: stage 0 captures the inputs with valid=in_valid (invalid input yields a bubble); stage k captures stage k-1.
- Flush of stage k while stage k-1 advances into it: flush wins, and the advancing instruction is discarded.
- stall_count increments on every edge where hazard=1 & stall_in=0, and saturates at 0xFFFFFFFF.

## Timing
- Reset (asynchronous, reset=0): all stages become bubbles and stall_count=0. Outputs: stage_valid=0, out_valid=0, out_data=0, out_dst=0, out_dst_wr=0. in_ready and hazard follow the inputs combinationally, so hazard=0.
- Latency: an input accepted at edge t is visible on out_* after edge t+STAGES-1, i.e. STAGES edges from presentation to stage STAGES-1 being loaded.
- Throughput is 1 per cycle with no stall or hazard.
- A load-use pair costs exactly one bubble, because hazard clears once the load leaves stage 0.
- Reset released mid-stream: the first edge after reset rises behaves as a normal advance.
- All outputs except in_ready and hazard are direct register outputs.

## Configuration
- PIPE_HAZARD_DETECT_EN defined: hazard logic and stall_count are present as described.
- Not defined: hazard is tied to 0, stall_count is tied to 0, the load field is not stored, and in_ready = ~stall_in.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0. Release, feed in_data=0x1, 0x2, 0x3 on consecutive cycles (STAGES=3) → out_data=0x1 appears 3 edges after the first presentation, then 0x2 and 0x3 on consecutive cycles.
- Load-use: load with dst=5 in stage 0, in_src1=5 → hazard=1 and in_ready=0 for one cycle, a bubble enters stage 0, and stall_count becomes 1. Repeat with dst=0 → no hazard.
- stall_in=1 for 4 cycles with a full chain → stage contents unchanged and in_ready=0. Release → resumes with no instruction lost or duplicated.
- flush_mask=3'b011 while stall_in=1 → stages 0–1 become bubbles and stage 2 is held.
- Saturation: force stall_count to 0xFFFFFFFE and run 3 hazard cycles → stall_count ends at 0xFFFFFFFF.
- Asynchronous reset asserted mid-stream between clock edges → outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline-register chain with per-stage flush, global stall and load-use hazard stall.
// Optional build macro PIPE_HAZARD_DETECT_EN enables hazard detection and the stall counter.
module pipe_stage_chain #(
  parameter int DATA_WIDTH     = 64,
  parameter int STAGES         = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_dst,
  input  logic                      in_dst_wr,
  input  logic                      in_load,
  input  logic [REG_ADDR_WIDTH-1:0] in_src1,
  input  logic [REG_ADDR_WIDTH-1:0] in_src2,
  input  logic                      stall_in,
  input  logic [STAGES-1:0]         flush_mask,
  output logic                      in_ready,
  output logic                      hazard,
  output logic [STAGES-1:0]         stage_valid,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [REG_ADDR_WIDTH-1:0] out_dst,
  output logic                      out_dst_wr,
  output logic [31:0]               stall_count
);

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [STAGES-1:0]         vldQ;
  logic [STAGES-1:0]         dstWrQ;
  logic [DATA_WIDTH-1:0]     dataQ [STAGES];
  logic [REG_ADDR_WIDTH-1:0] dstQ  [STAGES];
  logic                      hazardC;
  logic                      bubble0;

`ifdef PIPE_HAZARD_DETECT_EN
  logic [STAGES-1:0] loadQ;
  logic [31:0]       stallCnt;

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazardC = in_valid & vldQ[0] & loadQ[0] & dstWrQ[0] & (dstQ[0] != '0)
                 & ((dstQ[0] == in_src1) | (dstQ[0] == in_src2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (hazardC && !stall_in) begin
      stallCnt <= satInc(stallCnt);
    end
  end

  assign stall_count = stallCnt;
`else
  logic unusedHazardInputs;

  assign hazardC            = 1'b0;
  assign stall_count        = '0;
  assign unusedHazardInputs = ^{in_load, in_src1, in_src2, satInc(32'd0)};
`endif

  assign hazard   = hazardC;
  assign in_ready = ~stall_in & ~hazardC;
  // Stage 0 becomes a bubble on flush, or on advance with a hazard or an invalid input.
  assign bubble0  = flush_mask[0] | (~stall_in & (hazardC | ~in_valid));

  // stage 0: input capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vldQ[0]   <= 1'b0;
      dstWrQ[0] <= 1'b0;
      dataQ[0]  <= '0;
      dstQ[0]   <= '0;
`ifdef PIPE_HAZARD_DETECT_EN
      loadQ[0]  <= 1'b0;
`endif
    end else if (bubble0) begin
      vldQ[0]   <= 1'b0;
      dstWrQ[0] <= 1'b0;
      dataQ[0]  <= '0;
      dstQ[0]   <= '0;
`ifdef PIPE_HAZARD_DETECT_EN
      loadQ[0]  <= 1'b0;
`endif
    end else if (!stall_in) begin
      vldQ[0]   <= 1'b1;
      dstWrQ[0] <= in_dst_wr;
      dataQ[0]  <= in_data;
      dstQ[0]   <= in_dst;
`ifdef PIPE_HAZARD_DETECT_EN
      loadQ[0]  <= in_load;
`endif
    end
  end

  // stages 1..STAGES-1: shift from the previous stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < STAGES; k++) begin
        vldQ[k]   <= 1'b0;
        dstWrQ[k] <= 1'b0;
        dataQ[k]  <= '0;
        dstQ[k]   <= '0;
`ifdef PIPE_HAZARD_DETECT_EN
        loadQ[k]  <= 1'b0;
`endif
      end
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        if (flush_mask[k]) begin
          vldQ[k]   <= 1'b0;
          dstWrQ[k] <= 1'b0;
          dataQ[k]  <= '0;
          dstQ[k]   <= '0;
`ifdef PIPE_HAZARD_DETECT_EN
          loadQ[k]  <= 1'b0;
`endif
        end else if (!stall_in) begin
          vldQ[k]   <= vldQ[k-1];
          dstWrQ[k] <= dstWrQ[k-1];
          dataQ[k]  <= dataQ[k-1];
          dstQ[k]   <= dstQ[k-1];
`ifdef PIPE_HAZARD_DETECT_EN
          loadQ[k]  <= loadQ[k-1];
`endif
        end
      end
    end
  end

  assign stage_valid = vldQ;
  assign out_valid   = vldQ[STAGES-1];
  assign out_data    = dataQ[STAGES-1];
  assign out_dst     = dstQ[STAGES-1];
  assign out_dst_wr  = dstWrQ[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: vector table, directed corner cases and a random run
// compared against a stage-list reference model.
module tb_pipe_stage_chain;

  localparam int DW = 64;
  localparam int ST = 3;
  localparam int AW = 5;
`ifdef PIPE_HAZARD_DETECT_EN
  localparam bit HazEn = 1'b1;
`else
  localparam bit HazEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_dst;
  logic          in_dst_wr;
  logic          in_load;
  logic [AW-1:0] in_src1;
  logic [AW-1:0] in_src2;
  logic          stall_in;
  logic [ST-1:0] flush_mask;
  logic          in_ready;
  logic          hazard;
  logic [ST-1:0] stage_valid;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_dst;
  logic          out_dst_wr;
  logic [31:0]   stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_WIDTH(DW), .STAGES(ST), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_dst(in_dst),
    .in_dst_wr(in_dst_wr), .in_load(in_load), .in_src1(in_src1), .in_src2(in_src2),
    .stall_in(stall_in), .flush_mask(flush_mask), .in_ready(in_ready), .hazard(hazard),
    .stage_valid(stage_valid), .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst),
    .out_dst_wr(out_dst_wr), .stall_count(stall_count)
  );

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [AW-1:0] dst;
    logic          wr;
    logic          ld;
  } stg_t;

  stg_t        mdl [ST];
  logic [31:0] mdlCnt;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          expV;
    logic [DW-1:0] expD;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic mdlHazard();
    return HazEn && reset && in_valid && mdl[0].v && mdl[0].ld && mdl[0].wr &&
           (mdl[0].dst != '0) && (mdl[0].dst == in_src1 || mdl[0].dst == in_src2);
  endfunction

  task automatic mdlClear();
    for (int k = 0; k < ST; k++) mdl[k] = '0;
    mdlCnt = '0;
  endtask

  task automatic checkRegs();
    logic [ST-1:0] ev;
    for (int k = 0; k < ST; k++) ev[k] = mdl[k].v;
    chk("stage_valid", stage_valid, ev);
    chk("out_valid", out_valid, mdl[ST-1].v);
    chk("out_data", out_data, mdl[ST-1].d);
    chk("out_dst", out_dst, mdl[ST-1].dst);
    chk("out_dst_wr", out_dst_wr, mdl[ST-1].wr);
    chk("stall_count", stall_count, mdlCnt);
  endtask

  // Inputs are set just after a falling edge; this task checks the combinational
  // outputs, predicts the next state, crosses one rising edge and checks registers.
  task automatic stepCycle();
    logic hz;
    stg_t nxt [ST];
    #1;
    hz = mdlHazard();
    chk("hazard", hazard, hz);
    chk("in_ready", in_ready, !stall_in && !hz);
    nxt = mdl;
    if (!reset) begin
      for (int k = 0; k < ST; k++) nxt[k] = '0;
    end else begin
      if (!stall_in) begin
        for (int k = ST - 1; k > 0; k--) nxt[k] = mdl[k-1];
        if (hz || !in_valid) begin
          nxt[0] = '0;
        end else begin
          nxt[0].v   = 1'b1;
          nxt[0].d   = in_data;
          nxt[0].dst = in_dst;
          nxt[0].wr  = in_dst_wr;
          nxt[0].ld  = in_load;
        end
        if (hz && mdlCnt != 32'hFFFF_FFFF) mdlCnt = mdlCnt + 32'd1;
      end
      for (int k = 0; k < ST; k++) if (flush_mask[k]) nxt[k] = '0;
    end
    @(posedge clk);
    #1;
    mdl = nxt;
    checkRegs();
    @(negedge clk);
  endtask

  task automatic setIdle();
    in_valid   = 1'b0;
    in_data    = '0;
    in_dst     = '0;
    in_dst_wr  = 1'b0;
    in_load    = 1'b0;
    in_src1    = '0;
    in_src2    = '0;
    stall_in   = 1'b0;
    flush_mask = '0;
  endtask

  task automatic randIn();
    in_valid   = ($urandom_range(0, 3) != 0);
    in_data    = {$urandom, $urandom};
    in_dst     = AW'($urandom_range(0, 3));
    in_dst_wr  = $urandom_range(0, 3) != 0;
    in_load    = $urandom_range(0, 1) == 1;
    in_src1    = AW'($urandom_range(0, 3));
    in_src2    = AW'($urandom_range(0, 3));
    stall_in   = ($urandom_range(0, 4) == 0);
    flush_mask = ($urandom_range(0, 9) == 0) ? ST'($urandom) : '0;
  endtask

  task automatic feed(input logic [DW-1:0] d);
    setIdle();
    in_valid  = 1'b1;
    in_data   = d;
    in_dst    = AW'(d[3:0]);
    in_dst_wr = 1'b1;
    stepCycle();
  endtask

  initial begin
    tbl[0] = '{1'b1, 64'h1, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 64'h2, 1'b0, 64'h0};
    tbl[2] = '{1'b1, 64'h3, 1'b1, 64'h1};
    tbl[3] = '{1'b0, 64'h0, 1'b1, 64'h2};
    tbl[4] = '{1'b0, 64'h0, 1'b1, 64'h3};
    tbl[5] = '{1'b0, 64'h0, 1'b0, 64'h0};

    mdlClear();
    reset = 1'b0;
    randIn();
    @(negedge clk);

    // Held in reset with random inputs: everything stays cleared.
    for (int i = 0; i < 4; i++) begin
      randIn();
      stepCycle();
    end
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_out_data", out_data, 0);

    // Release and stream 1,2,3.
    setIdle();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      stepCycle();
      chk("tbl_out_valid", out_valid, tbl[i].expV);
      chk("tbl_out_data", out_data, tbl[i].expD);
    end

    // Load-use on r5.
    setIdle();
    in_valid = 1'b1; in_load = 1'b1; in_dst = 5'd5; in_dst_wr = 1'b1; in_data = 64'h55;
    stepCycle();
    in_load = 1'b0; in_dst = 5'd7; in_src1 = 5'd5; in_data = 64'hAA;
    #1;
    chk("lu_hazard", hazard, HazEn);
    chk("lu_in_ready", in_ready, !HazEn);
    stepCycle();
    chk("lu_stage0_valid", stage_valid[0], !HazEn);
    chk("lu_stall_count", stall_count, HazEn ? 32'd1 : 32'd0);
    #1;
    chk("lu_hazard_clear", hazard, 1'b0);
    stepCycle();

    // Load to r0 never stalls a consumer of r0.
    in_load = 1'b1; in_dst = 5'd0; in_src1 = 5'd3; in_data = 64'hB0;
    stepCycle();
    in_load = 1'b0; in_dst = 5'd2; in_src1 = 5'd0; in_src2 = 5'd0;
    #1;
    chk("lu_r0_hazard", hazard, 1'b0);
    stepCycle();

    // Global stall on a full chain.
    feed(64'h100); feed(64'h101); feed(64'h102);
    setIdle();
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      stepCycle();
      chk("stall_out_data", out_data, 64'h100);
      chk("stall_stage_valid", stage_valid, 3'b111);
    end
    setIdle();
    stepCycle();
    chk("resume_1", out_data, 64'h101);
    stepCycle();
    chk("resume_2", out_data, 64'h102);
    stepCycle();
    chk("resume_3_valid", out_valid, 1'b0);

    // Flush of stages 0-1 during a stall.
    feed(64'h200); feed(64'h201); feed(64'h202);
    setIdle();
    stall_in   = 1'b1;
    flush_mask = 3'b011;
    stepCycle();
    chk("flush_stage_valid", stage_valid, 3'b100);
    chk("flush_out_data", out_data, 64'h200);

    // Random run.
    for (int i = 0; i < 400; i++) begin
      randIn();
      stepCycle();
    end

    // Asynchronous reset between clock edges.
    randIn();
    #2;
    reset = 1'b0;
    #1;
    chk("async_stage_valid", stage_valid, 0);
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_data", out_data, 0);
    chk("async_stall_count", stall_count, 0);
    mdlClear();
    @(negedge clk);
    stepCycle();
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      randIn();
      stepCycle();
    end

`ifdef PIPE_HAZARD_DETECT_EN
    // Counter saturation.
    setIdle();
    force dut.stallCnt = 32'hFFFF_FFFE;
    #1;
    release dut.stallCnt;
    mdlCnt = 32'hFFFF_FFFE;
    in_valid = 1'b1; in_load = 1'b1; in_dst = 5'd5; in_dst_wr = 1'b1; in_src1 = 5'd5;
    for (int i = 0; i < 6; i++) stepCycle();
    chk("sat_stall_count", stall_count, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
